// File: rtl/alu16_seq.sv
// alu16_seq: runs 16-bit ADD/ADC/SUB/SBB as two passes through an external
// 8-bit ALU. The low byte goes first, then the high byte with the carry/borrow
// chained. The result and the merged flag byte come back with a one-cycle done pulse.
// Optional build macro ALU16_CMP_EN adds iCmp. iCmp forces a subtract that
// updates only the flags, which makes it a 16-bit compare.
// oState exposes the FSM state (IDLE=0, LO=1, HI=2, DONE=3) for debug.
module alu16_seq #(
    parameter int DATASIZE = 8,
    parameter int FLAG_S   = 7,
    parameter int FLAG_Z   = 6,
    parameter int FLAG_A   = 4,
    parameter int FLAG_P   = 2,
    parameter int FLAG_C   = 0
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iReq,
    input  logic [1:0]            iOp,
    input  logic [2*DATASIZE-1:0] iA,
    input  logic [2*DATASIZE-1:0] iB,
    input  logic [7:0]            iF,
`ifdef ALU16_CMP_EN
    input  logic                  iCmp,
`endif
    output logic                  oBusy,
    output logic                  oDone,
    output logic [2*DATASIZE-1:0] oY,
    output logic [7:0]            oF,
    output logic [2:0]            oAluS,
    output logic [DATASIZE-1:0]   oAluA,
    output logic [DATASIZE-1:0]   oAluB,
    output logic [7:0]            oAluF,
    input  logic [DATASIZE-1:0]   iAluY,
    input  logic [7:0]            iAluF,
    output logic [1:0]            oState
);

    localparam int W2 = 2 * DATASIZE;

    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} stateT;

    // Handshake: iReq is sampled only in IDLE. A request seen there is accepted
    // on that clock edge and is never queued. oDone is high for the single DONE
    // cycle, and oY/oF keep their values until the next completion.

    stateT               state;
    stateT               stateNext;
    logic [W2-1:0]       aReg;
    logic [W2-1:0]       bReg;
    logic [1:0]          opReg;
    logic [7:0]          fReg;
    logic [DATASIZE-1:0] yLo;
    logic [7:0]          fLo;
    logic                updY;
    logic [7:0]          fMerged;
    logic [1:0]          opAccept;

`ifdef ALU16_CMP_EN
    logic cmpReg;
    // A compare always subtracts; iOp[0] still selects whether the borrow is used.
    assign opAccept = iCmp ? {1'b1, iOp[0]} : iOp;
    assign updY     = ~cmpReg;
`else
    assign opAccept = iOp;
    assign updY     = 1'b1;
`endif

    assign oBusy  = (state != IDLE);
    assign oDone  = (state == DONE);
    assign oState = state;

    // State register plus operand latches, low-pass capture and result registers.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state <= IDLE;
            aReg  <= '0;
            bReg  <= '0;
            opReg <= '0;
            fReg  <= '0;
            yLo   <= '0;
            fLo   <= '0;
            oY    <= '0;
            oF    <= '0;
`ifdef ALU16_CMP_EN
            cmpReg <= 1'b0;
`endif
        end else begin
            state <= stateNext;
            if (state == IDLE && iReq) begin
                aReg  <= iA;
                bReg  <= iB;
                opReg <= opAccept;
                fReg  <= iF;
`ifdef ALU16_CMP_EN
                cmpReg <= iCmp;
`endif
            end
            if (state == LO) begin
                yLo <= iAluY;
                fLo <= iAluF;
            end
            if (state == HI) begin
                oF <= fMerged;
                if (updY) begin
                    oY <= {iAluY, yLo};
                end
            end
        end
    end

    // Flag merge: the high pass supplies S/AC/P/C. Z must hold for both bytes.
    // All other bits pass through from the caller's flag register.
    always_comb begin
        fMerged         = fReg;
        fMerged[FLAG_S] = iAluF[FLAG_S];
        fMerged[FLAG_Z] = fLo[FLAG_Z] & iAluF[FLAG_Z];
        fMerged[FLAG_A] = iAluF[FLAG_A];
        fMerged[FLAG_P] = iAluF[FLAG_P];
        fMerged[FLAG_C] = iAluF[FLAG_C];
    end

    // Next state and ALU drive. The high pass forces op bit 0 so the low-pass carry/borrow chains.
    always_comb begin
        stateNext = state;
        oAluS     = 3'b000;
        oAluA     = '0;
        oAluB     = '0;
        oAluF     = '0;
        case (state)
            IDLE: begin
                if (iReq) begin
                    stateNext = LO;
                end
            end
            LO: begin
                stateNext = HI;
                oAluS     = {1'b0, opReg};
                oAluA     = aReg[DATASIZE-1:0];
                oAluB     = bReg[DATASIZE-1:0];
                oAluF     = fReg;
            end
            HI: begin
                stateNext = DONE;
                oAluS     = {1'b0, opReg[1], 1'b1};
                oAluA     = aReg[W2-1:DATASIZE];
                oAluB     = bReg[W2-1:DATASIZE];
                oAluF     = fLo;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Two-pass sequencer that drives the existing 8-bit ALU (3-bit op select, flag vector in/out) to perform 16-bit ADD/ADC/SUB/SBB for the core's register-pair instructions (DAD-style adds, pair subtracts).
- Sits between the instruction decoder/control unit and one ALU instance.
- Owns the ALU's select, operand and flag inputs while busy, and returns a merged 16-bit result and flag byte.

Parameters:
- DATASIZE, 8, ALU width; the 16-bit operands are 2*DATASIZE.
- FLAG_S, 7, sign flag bit index.
- FLAG_Z, 6, zero flag bit index.
- FLAG_A, 4, auxiliary carry flag bit index.
- FLAG_P, 2, parity flag bit index.
- FLAG_C, 0, carry/borrow flag bit index.

Ports:
- iClk  input  1  system clock, all state on rising edge
- iRstN  input  1  synchronous active-low reset
- iReq  input  1  start request, sampled only in IDLE
- iOp  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBB
- iA  input  16  operand A (minuend for SUB)
- iB  input  16  operand B (subtrahend for SUB)
- iF  input  8  current flag register; carry bit used by ADC/SBB; non-arithmetic bits passed through
- oBusy  output  1  high from the cycle after accept until DONE is left
- oDone  output  1  one-cycle pulse, oY/oF valid
- oY  output  16  result, held until next completion
- oF  output  8  merged flags, held until next completion
- oAluS  output  3  ALU op select
- oAluA  output  8  ALU operand A
- oAluB  output  8  ALU operand B
- oAluF  output  8  flag vector fed to the ALU
- iAluY  input  8  ALU result
- iAluF  input  8  ALU flag output

Behaviour:
- Reset (iRstN=0 at a clock edge): state=IDLE; oBusy=0, oDone=0, oY=0, oF=0, oAluS=000, oAluA=0, oAluB=0, oAluF=0, all internal latches 0.
- Reset applies from any state. An in-flight operation is discarded with no oDone.
- State machine:
  - IDLE: if iReq=1, latch iA, iB, iOp, iF; go to LO. Otherwise stay.
  - LO: go to HI.
  - HI: go to DONE.
  - DONE: go to IDLE.
- Latency: accept edge -> LO -> HI -> DONE. oDone is high exactly 3 cycles after the accept edge, for 1 cycle.
- oBusy=1 in LO, HI and DONE. iReq is ignored while busy; no queuing.
- Back-to-back operation: the next request may be accepted on the edge that leaves DONE into IDLE only if sampled in IDLE, so the minimum spacing between accepts is 4 cycles.
- ALU drive is combinational from state and latches:
  - IDLE/DONE: oAluS=000; operands are don't-care, driven 0.
  - LO:
    - oAluA=A[7:0], oAluB=B[7:0].
    - oAluS = {0, op[1], op[0]}, i.e. ADD=000, ADC=001, SUB=010, SBB=011.
    - oAluF = latched iF, so the ALU's carry-in is iF[FLAG_C] only for ADC/SBB.
  - HI:
    - oAluA=A[15:8], oAluB=B[15:8].
    - oAluS = {0, op[1], 1}, so carry/borrow is always chained.
    - oAluF = flags captured at the end of LO.
- Capture:
  - End of LO: Ylo=iAluY; record low-pass flags; zlo = low-pass FLAG_Z.
  - End of HI: oY={iAluY, Ylo}.
- Flag merge at end of HI:
  - S, AC, P, C taken from the high pass.
  - Z = zlo & high-pass Z.
  - Bits 5, 3, 1 copied from the latched iF.
- C is a borrow for SUB/SBB, per the ALU's subtractor convention.
- oY/oF are updated only at the end of HI and are stable through DONE and afterwards.
- Wrap-around: results are modulo 2^16; the carry-out of bit 15 appears only in oF[FLAG_C].

Optional Feature:
- Macro ALU16_CMP_EN.
- When defined:
  - Adds input iCmp (1 bit), latched at accept.
  - If set, the operation is forced to SUB/SBB per iOp[0] and oF is updated as normal.
  - oY is NOT updated and keeps its previous value, giving a 16-bit compare.
- When undefined: no iCmp port; every completion updates oY.

Test Plan:
- Reset/idle: hold iRstN=0 for 2 cycles, then release -> oBusy=0, oDone=0, oY=0000, oF=00, oAluS=000.
- ADD with byte carry: A=00FF, B=0001, ADD -> oDone on 3rd cycle after accept; oY=0100, C=0, Z=0, S=0.
- Full wrap: A=FFFF, B=0001, ADD -> oY=0000, Z=1, C=1. Also verify oAluS=000 in LO and 001 in HI.
- Carry-in: iF[0]=1, A=1234, B=0001, ADC -> oY=1236, C=0. Then SBB with iF[0]=1, A=1000, B=0000 -> oY=0FFF.
- Borrow/sign: A=0000, B=0001, SUB -> oY=FFFF, C=1, S=1, Z=0. iReq held high during busy -> exactly one oDone per 4 cycles.
- Reset mid-op: accept ADD, assert iRstN=0 in HI -> no oDone, oY=0000, state IDLE. A following request completes normally.
